// File: rtl/gs_row_scheduler_if.sv
// Load, core-job and result-stream signals of gs_row_scheduler.
// master: the scheduler side; slave: the surrounding environment (loader, core, sink).
interface gs_row_scheduler_if #(
  parameter int N  = 8,
  parameter int XW = 32
);
  logic                    i_valid;
  logic [31:0]             i_data;
  logic                    o_ready;
  logic                    core_clr;
  logic                    core_start;
  logic [8*(N-1)-1:0]      core_a;
  logic [7:0]              core_b;
  logic [31:0]             core_adown;
  logic [XW*(N-1)-1:0]     core_x;
  logic                    core_valid;
  logic [XW-1:0]           core_x_next;
  logic                    o_valid;
  logic [XW-1:0]           o_x;
  logic                    o_busy;
  logic                    o_done;

  modport master (
    input  i_valid, i_data, core_valid, core_x_next,
    output o_ready, core_clr, core_start, core_a, core_b, core_adown, core_x,
           o_valid, o_x, o_busy, o_done
  );

  modport slave (
    output i_valid, i_data, core_valid, core_x_next,
    input  o_ready, core_clr, core_start, core_a, core_b, core_adown, core_x,
           o_valid, o_x, o_busy, o_done
  );
endinterface

// File: rtl/gs_row_scheduler.sv
// Gauss-Seidel row scheduler: loads an NxN system, runs ITER in-place sweeps on the core, streams x.
// Optional GS_EARLY_STOP_EN: leave after any sweep in which no x value changed.
module gs_row_scheduler #(
  parameter int N    = 8,
  parameter int ITER = 16,
  parameter int XW   = 32
) (
  input logic              i_clk,
  input logic              i_reset,
  gs_row_scheduler_if.master bus
);
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(N + 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
  localparam logic [CW-1:0] COL_B    = CW'(N);
  localparam logic [CW-1:0] COL_LAST = CW'(N + 1);
  localparam logic [7:0]    ITER_L   = 8'(ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      a_q     [N][N];
  logic [7:0]      b_q     [N];
  logic [31:0]     adown_q [N];
  logic [XW-1:0]   x_q     [N];
  logic [XW-1:0]   x_d     [N];
  logic [RW-1:0]   ld_row_q, ld_row_d;
  logic [CW-1:0]   ld_col_q, ld_col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [7:0]      iter_q, iter_d;
  logic [RW-1:0]   out_k_q, out_k_d;
  logic            done_q, done_d;
  logic            accept;
  logic [RW-1:0]   lane_col;
`ifdef GS_EARLY_STOP_EN
  logic            chg_q, chg_d;
  logic            sweep_chg;
`endif

  always_comb begin
    state_d  = state_q;
    ld_row_d = ld_row_q;
    ld_col_d = ld_col_q;
    row_d    = row_q;
    iter_d   = iter_q;
    out_k_d  = out_k_q;
    done_d   = 1'b0;
    x_d      = x_q;
`ifdef GS_EARLY_STOP_EN
    chg_d     = chg_q;
    sweep_chg = chg_q;
`endif
    bus.o_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    accept      = bus.i_valid && bus.o_ready;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          state_d = S_LOAD;
          if (ld_col_q == COL_LAST) begin
            ld_col_d = '0;
            if (ld_row_q == ROW_LAST) begin
              ld_row_d = '0;
              row_d    = '0;
              iter_d   = '0;
              for (int unsigned k = 0; k < N; k++) x_d[k] = '0;
`ifdef GS_EARLY_STOP_EN
              chg_d = 1'b0;
`endif
              state_d = S_CLR;
            end else begin
              ld_row_d = ld_row_q + 1'b1;
            end
          end else begin
            ld_col_d = ld_col_q + 1'b1;
          end
        end
      end
      S_CLR:   state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.core_valid) begin
          x_d[row_q] = bus.core_x_next;
          state_d    = S_CLR;
`ifdef GS_EARLY_STOP_EN
          sweep_chg = chg_q || (bus.core_x_next != x_q[row_q]);
          chg_d     = sweep_chg;
`endif
          if (row_q == ROW_LAST) begin
            row_d  = '0;
            iter_d = iter_q + 8'd1;
            if (iter_d == ITER_L) state_d = S_OUT;
`ifdef GS_EARLY_STOP_EN
            if (!sweep_chg) state_d = S_OUT;
            chg_d = 1'b0;
`endif
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_OUT: begin
        out_k_d = out_k_q + 1'b1;
        if (out_k_q == ROW_LAST) begin
          out_k_d = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operands follow row_q combinationally; row_q and x_q only move at the WAIT exit edge.
  always_comb begin
    bus.core_a = '0;
    bus.core_x = '0;
    lane_col   = '0;
    for (int unsigned l = 0; l < N - 1; l++) begin
      lane_col = (RW'(l) < row_q) ? RW'(l) : RW'(l + 1);
      bus.core_a[8*(N-2-l) +: 8]   = a_q[row_q][lane_col];
      bus.core_x[XW*(N-2-l) +: XW] = x_q[lane_col];
    end
    bus.core_b     = b_q[row_q];
    bus.core_adown = adown_q[row_q];
  end

  assign bus.core_clr   = (state_q == S_CLR);
  assign bus.core_start = (state_q == S_START);
  assign bus.o_valid    = (state_q == S_OUT);
  assign bus.o_x        = (state_q == S_OUT) ? x_q[out_k_q] : '0;
  assign bus.o_busy     = (state_q != S_IDLE);
  assign bus.o_done     = done_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      ld_row_q <= '0;
      ld_col_q <= '0;
      row_q    <= '0;
      iter_q   <= '0;
      out_k_q  <= '0;
      done_q   <= 1'b0;
      for (int unsigned k = 0; k < N; k++) x_q[k] <= '0;
`ifdef GS_EARLY_STOP_EN
      chg_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ld_row_q <= ld_row_d;
      ld_col_q <= ld_col_d;
      row_q    <= row_d;
      iter_q   <= iter_d;
      out_k_q  <= out_k_d;
      done_q   <= done_d;
      x_q      <= x_d;
`ifdef GS_EARLY_STOP_EN
      chg_q <= chg_d;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned r = 0; r < N; r++) begin
        b_q[r]     <= '0;
        adown_q[r] <= '0;
        for (int unsigned c = 0; c < N; c++) a_q[r][c] <= '0;
      end
    end else if (accept) begin
      if (ld_col_q < COL_B) begin
        a_q[ld_row_q][ld_col_q[RW-1:0]] <= bus.i_data[7:0];
      end else if (ld_col_q == COL_B) begin
        b_q[ld_row_q] <= bus.i_data[7:0];
      end else begin
        adown_q[ld_row_q] <= bus.i_data;
      end
    end
  end
endmodule

// File: tb/tb_gs_row_scheduler.sv
// Randomised bench for gs_row_scheduler with a queue-fed behavioural core and a sweep-level reference model.
module tb_gs_row_scheduler;
  localparam int N       = 8;
  localparam int XW      = 32;
  localparam int TB_ITER = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gs_row_scheduler_if #(.N(N), .XW(XW)) bus ();
  gs_row_scheduler #(.N(N), .ITER(TB_ITER), .XW(XW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]    ma  [N][N];
  logic [7:0]    mb  [N];
  logic [31:0]   mad [N];
  logic [XW-1:0] mx  [N];
  logic [31:0]   words[$];
  logic [XW-1:0] res_q[$];
  logic [XW-1:0] res_list[$];

  int unsigned   cyc     = 0;
  int unsigned   nstart  = 0;
  logic          clr_last = 1'b0;
  logic [2:0]    ccnt    = '0;
  logic          cvalid  = 1'b0;
  logic [XW-1:0] cres    = '0;

  assign bus.core_valid  = cvalid;
  assign bus.core_x_next = cres;

  // Core stand-in: result appears 5 cycles after start and holds until the next clear.
  // It deliberately ignores i_reset so an aborted job still delivers a late result.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    clr_last <= bus.core_clr;
    if (bus.core_start) nstart <= nstart + 1;
    if (bus.core_clr) begin
      ccnt   <= '0;
      cvalid <= 1'b0;
    end else if (bus.core_start) begin
      ccnt <= 3'd4;
      if (res_q.size() > 0) cres <= res_q.pop_front();
    end else if (ccnt != 0) begin
      ccnt <= ccnt - 3'd1;
      if (ccnt == 3'd1) cvalid <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] exp_a(input int r);
    logic [55:0] v;
    int j;
    v = '0;
    for (int l = 0; l < N - 1; l++) begin
      j = (l < r) ? l : l + 1;
      v = {v[47:0], ma[r][j]};
    end
    return v;
  endfunction

  function automatic logic [XW*(N-1)-1:0] exp_x(input int r);
    logic [XW*(N-1)-1:0] v;
    int j;
    v = '0;
    for (int l = 0; l < N - 1; l++) begin
      j = (l < r) ? l : l + 1;
      v = {v[XW*(N-2)-1:0], mx[j]};
    end
    return v;
  endfunction

  // which: 0 = core_start, 1 = core_valid, other = o_valid
  task automatic wait_for(input int which, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      case (which)
        0:       ok = bus.core_start;
        1:       ok = bus.core_valid;
        default: ok = bus.o_valid;
      endcase
    end
  endtask

  task automatic load_words();
    int acc;
    int guard;
    acc   = 0;
    guard = 0;
    while (acc < N * (N + 2) && guard < 1000) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(0, 2) == 0) begin
        bus.i_valid = 1'b0;
        bus.i_data  = $urandom();
      end else begin
        bus.i_valid = 1'b1;
        bus.i_data  = words[acc];
      end
      if (bus.i_valid && bus.o_ready) acc++;
    end
    check("load_count", acc, N * (N + 2));
    // A surplus word offered in the clear cycle must be refused.
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = $urandom();
    check("clr_after_load", bus.core_clr, 1);
    check("ready_in_clr", bus.o_ready, 0);
    check("busy_in_clr", bus.o_busy, 1);
  endtask

  // mode 0: a_ij = 10i+j with row+1 results; 1: fully random; 2: A = 2I diagonal system
  task automatic run(input int mode, input bit do_rst);
    bit ok, abort, chg;
    int k, nsw;
    int unsigned last_cyc, st0;
    logic [31:0] w;
    logic [XW-1:0] r;
    logic [XW*(N-1)-1:0] ex_x;

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    words.delete();
    res_q.delete();
    res_list.delete();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (mode)
          0:       ma[i][j] = 8'(10 * i + j);
          1:       ma[i][j] = 8'($urandom());
          default: ma[i][j] = (i == j) ? 8'd2 : 8'd0;
        endcase
      end
      mb[i]  = (mode == 2) ? 8'd4 : 8'($urandom());
      mad[i] = (mode == 2) ? 32'h2000_0000 : $urandom();
      mx[i]  = '0;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w = $urandom();
        w[7:0] = ma[i][j];
        words.push_back(w);
      end
      w = $urandom();
      w[7:0] = mb[i];
      words.push_back(w);
      words.push_back(mad[i]);
    end
    for (int t = 0; t < TB_ITER * N; t++) begin
      case (mode)
        0:       r = XW'((t % N) + 1) << 24;
        1:       r = $urandom();
        default: r = 32'h0200_0000;
      endcase
      res_q.push_back(r);
      res_list.push_back(r);
    end

    st0 = nstart;
    load_words();

    abort    = 1'b0;
    k        = 0;
    nsw      = 0;
    last_cyc = 0;
    for (int sw = 0; sw < TB_ITER; sw++) begin
      chg = 1'b0;
      for (int row = 0; row < N; row++) begin
        wait_for(0, 40, ok);
        check("start_seen", ok, 1);
        if (!ok) begin
          abort = 1'b1;
          break;
        end
        if (k == 0) bus.i_valid = 1'b0;
        check("clr_before_start", clr_last, 1);
        if (k > 0) check("start_gap", cyc - last_cyc, 7);
        last_cyc = cyc;
        ex_x = exp_x(row);
        check("core_a", bus.core_a, exp_a(row));
        check("core_b", bus.core_b, mb[row]);
        check("core_adown", bus.core_adown, mad[row]);
        check("core_x", bus.core_x, ex_x);
        if (mode == 0 && sw == 0 && row == 3)
          check("pack_row3", bus.core_a, 56'h1E1F20_22232425);
        if (mode == 0 && sw == 0 && row == 1)
          check("gs_row1_x", bus.core_x, {32'h0100_0000, 192'h0});
        if (do_rst && sw == 1 && row == 5) begin
          @(negedge clk);
          @(negedge clk);
          rst = 1'b1;
          #1;
          check("reset_outputs",
                {bus.o_busy, bus.core_clr, bus.core_start, bus.o_valid, bus.o_done,
                 bus.o_ready, bus.o_x},
                {5'b0, 1'b1, 32'h0});
          @(negedge clk);
          rst = 1'b0;
          repeat (6) @(negedge clk);
          check("late_valid_seen", bus.core_valid, 1);
          check("late_valid_idle", bus.o_busy, 0);
          check("late_valid_x", bus.core_x, '0);
          abort = 1'b1;
          break;
        end
        wait_for(1, 20, ok);
        check("valid_seen", ok, 1);
        if (!ok) begin
          abort = 1'b1;
          break;
        end
        check("hold_a", bus.core_a, exp_a(row));
        check("hold_x", bus.core_x, ex_x);
        r = res_list[k];
        k++;
        if (r !== mx[row]) chg = 1'b1;
        mx[row] = r;
      end
      if (abort) break;
      nsw++;
`ifdef GS_EARLY_STOP_EN
      if (!chg) break;
`endif
    end
    if (abort) return;

    wait_for(2, 20, ok);
    check("out_seen", ok, 1);
    if (!ok) return;
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      check("o_valid", bus.o_valid, 1);
      check("o_x", bus.o_x, mx[i]);
    end
    @(negedge clk);
    check("o_done", bus.o_done, 1);
    check("o_valid_end", bus.o_valid, 0);
    check("busy_idle", bus.o_busy, 0);
    @(negedge clk);
    check("o_done_pulse", bus.o_done, 0);
    check("n_start", nstart - st0, nsw * N);
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_state",
          {bus.o_busy, bus.core_clr, bus.core_start, bus.o_valid, bus.o_done,
           bus.o_ready, bus.o_x},
          {5'b0, 1'b1, 32'h0});
    check("reset_core_x", bus.core_x, '0);
    rst = 1'b0;

    run(0, 1'b0);
    run(1, 1'b0);
    run(2, 1'b0);
    run(1, 1'b1);
    run(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
